// File: rtl/rot_arbiter.sv
// rot_arbiter: two requesters share one 32-bit rotate datapath.
// Round-robin grant, valid/ready handshakes on both inputs and on the output,
// single-entry registered result buffer tagged with the issuing requester id.
// ROL is performed as ROR by (32 - amt) mod 32.
// Optional build macro ROT_STATS_EN adds saturating per-port grant counters
// (grant0_cnt/grant1_cnt, CNT_W bits wide).
module rot_arbiter #(
    parameter int unsigned CNT_W      = 16,
    parameter bit          RESET_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        in0_valid,
    output logic        in0_ready,
    input  logic        in0_op,
    input  logic [31:0] in0_data,
    input  logic [4:0]  in0_amt,
    input  logic        in1_valid,
    output logic        in1_ready,
    input  logic        in1_op,
    input  logic [31:0] in1_data,
    input  logic [4:0]  in1_amt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_id
`ifdef ROT_STATS_EN
    ,
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state;
    logic        prio;
    logic        grant0;
    logic        grant1;
    logic        slot_free;
    logic        acc0;
    logic        acc1;
    logic        sel_op;
    logic [31:0] sel_data;
    logic [4:0]  sel_amt;
    logic [4:0]  ror_amt;
    logic [31:0] rot_res;

    // Buffer occupancy is the FSM state itself
    assign out_valid = (state == FULL);

    // Grant depends only on the valids and the priority pointer
    always_comb begin
        grant0    = in0_valid & (~in1_valid | ~prio);
        grant1    = in1_valid & (~in0_valid |  prio);
        slot_free = ~out_valid | out_ready;
        in0_ready = grant0 & ~clr & slot_free;
        in1_ready = grant1 & ~clr & slot_free;
        acc0      = in0_valid & in0_ready;
        acc1      = in1_valid & in1_ready;
    end

    // Operand select and rotate; left rotates become right rotates by the complement
    always_comb begin
        sel_op   = grant1 ? in1_op   : in0_op;
        sel_data = grant1 ? in1_data : in0_data;
        sel_amt  = grant1 ? in1_amt  : in0_amt;
        ror_amt  = sel_op ? (5'd0 - sel_amt) : sel_amt;
        rot_res  = (sel_data >> ror_amt) | (sel_data << (6'd32 - {1'b0, ror_amt}));
    end

    // Result buffer FSM, priority pointer and registered result/id
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= EMPTY;
            out_data <= '0;
            out_id   <= 1'b0;
            prio     <= RESET_PRIO;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc0 | acc1) begin
                        state    <= FULL;
                        out_data <= rot_res;
                        out_id   <= acc1;
                        prio     <= ~acc1;
                    end
                end
                FULL: begin
                    if (acc0 | acc1) begin
                        state    <= FULL;
                        out_data <= rot_res;
                        out_id   <= acc1;
                        prio     <= ~acc1;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef ROT_STATS_EN
    // Saturating per-port accept counters
    always_ff @(posedge clk) begin
        if (clr) begin
            grant0_cnt <= '0;
            grant1_cnt <= '0;
        end else begin
            if (acc0 && (grant0_cnt != '1))
                grant0_cnt <= grant0_cnt + CNT_W'(1);
            if (acc1 && (grant1_cnt != '1))
                grant1_cnt <= grant1_cnt + CNT_W'(1);
        end
    end
`else
    // CNT_W only sizes the statistics counters; this empty block keeps it referenced
    generate
        if (CNT_W == 0) begin : g_no_stats
        end
    endgenerate
`endif

endmodule
